// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer and its peak tracker.
// Holds the default transform geometry, the complex sample layout
// (real in the upper half, imaginary in the lower half) and the frame
// sequencer state encoding.
package fft_pkg;

  localparam int bit_width = 16;
  localparam int M         = 9;
  localparam int N         = 512;
  localparam int MAG_W     = bit_width + 1;

  typedef struct packed {
    logic signed [bit_width-1:0] re;
    logic signed [bit_width-1:0] im;
  } complex_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    START,
    WAIT,
    SCAN,
    REPORT
  } seq_state_t;

endpackage

// File: rtl/fft_peak_tracker.sv
// Running-maximum tracker for the spectrum scan.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - start a new scan; the next valid bin seeds the maximum
//   valid       - data holds the bin given by bin
//   bin, data   - bin index and {re, im} bin contents
//   max_bin     - index of the largest bin seen so far, including the
//                 bin presented this cycle (combinational look-ahead)
//   max_mag     - |re|+|im| of that bin, unsigned bit_width+1 bits
module fft_peak_tracker #(
  parameter int bit_width = 16,
  parameter int M         = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [M-1:0]           bin,
  input  logic [2*bit_width-1:0] data,
  output logic [M-1:0]           max_bin,
  output logic [bit_width:0]     max_mag
);

  localparam int mag_w = bit_width + 1;

  logic [bit_width-1:0] re;
  logic [bit_width-1:0] im;
  logic [mag_w-1:0]     re_ext;
  logic [mag_w-1:0]     im_ext;
  logic [mag_w-1:0]     abs_re;
  logic [mag_w-1:0]     abs_im;
  logic [mag_w-1:0]     mag;
  logic [M-1:0]         bin_q;
  logic [mag_w-1:0]     mag_q;
  logic                 empty_q;
  logic                 take;

  assign re = data[2*bit_width-1:bit_width];
  assign im = data[bit_width-1:0];

  // One extra bit means the most negative input negates exactly.
  assign re_ext = {re[bit_width-1], re};
  assign im_ext = {im[bit_width-1], im};
  assign abs_re = re_ext[mag_w-1] ? (~re_ext + mag_w'(1)) : re_ext;
  assign abs_im = im_ext[mag_w-1] ? (~im_ext + mag_w'(1)) : im_ext;
  assign mag    = abs_re + abs_im;

  // Strictly greater only, so on a tie the earlier (lower) bin stays.
  assign take = valid && (empty_q || (mag > mag_q));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bin_q   <= '0;
      mag_q   <= '0;
      empty_q <= 1'b1;
    end else if (take) begin
      bin_q   <= bin;
      mag_q   <= mag;
      empty_q <= 1'b0;
    end
  end

  // Look-ahead lets the owner capture the final result in the same
  // cycle the last bin is compared.
  assign max_bin = take ? bin : bin_q;
  assign max_mag = take ? mag : mag_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller in front of the FFT core. Per frame it clears the
// core, loads N real samples, starts the transform, waits for done (with
// a timeout), scans bins 1..N/2-1 for the largest |re|+|im| and reports
// that bin.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   enable                     - frames begin only while high
//   sample_valid/sample/sample_ready - input sample stream
//   fft_reset/fft_load/fft_adr/fft_wd/fft_start - core control
//   fft_done/fft_rd            - core status and bin read data
//   peak_bin/peak_mag/result_valid - last frame's peak
//   timeout                    - pulse when the core never finished
//   drop_count                 - saturating count of refused samples
//   state_dbg                  - current sequencer state
//
// Handshake: a sample transfers in any cycle where sample_valid and
// sample_ready are both high; sample_ready does not depend on
// sample_valid, and a refused sample is not held for later.
module fft_frame_sequencer #(
  parameter int bit_width = 16,
  parameter int M         = 9,
  parameter int N         = 512,
  parameter int WAIT_MAX  = 16384
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sample_valid,
  input  logic [bit_width-1:0]   sample,
  output logic                   sample_ready,
  output logic                   fft_reset,
  output logic                   fft_load,
  output logic [M-1:0]           fft_adr,
  output logic [2*bit_width-1:0] fft_wd,
  output logic                   fft_start,
  input  logic                   fft_done,
  input  logic [2*bit_width-1:0] fft_rd,
  output logic [M-1:0]           peak_bin,
  output logic [bit_width:0]     peak_mag,
  output logic                   result_valid,
  output logic                   timeout,
  output logic [7:0]             drop_count,
  output fft_pkg::seq_state_t    state_dbg
);

  import fft_pkg::*;

  localparam int ww   = $clog2(WAIT_MAX) + 1;
  localparam int half = N / 2;

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [M-1:0]       sample_cnt_q;
  logic [ww-1:0]      wait_cnt_q;
  logic [M-1:0]       scan_adr_q;
  logic               scan_issue;
  logic               drain;
  logic               rd_valid_q;
  logic [M-1:0]       rd_bin_q;
  logic [M-1:0]       max_bin;
  logic [bit_width:0] max_mag;

  assign state_dbg    = state_q;
  assign sample_ready = (state_q == LOAD);
  // scan_adr_q == N/2 marks the drain cycle: no read issued, the last
  // returned bin is compared.
  assign scan_issue   = (state_q == SCAN) && (scan_adr_q != M'(half));
  assign drain        = (state_q == SCAN) && (scan_adr_q == M'(half));

  always_comb begin
    state_d      = state_q;
    fft_reset    = 1'b0;
    fft_load     = 1'b0;
    fft_start    = 1'b0;
    fft_adr      = '0;
    fft_wd       = '0;
    timeout      = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = CLEAR;
      end
      CLEAR: begin
        fft_reset = 1'b1;
        state_d   = LOAD;
      end
      LOAD: begin
        fft_adr = sample_cnt_q;
        if (sample_valid) begin
          fft_load = 1'b1;
          fft_wd   = {sample, {bit_width{1'b0}}};
          if (sample_cnt_q == M'(N - 1)) state_d = START;
        end
      end
      START: begin
        fft_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (fft_done) begin
          state_d = SCAN;
        end else if (wait_cnt_q == ww'(WAIT_MAX - 1)) begin
          timeout = 1'b1;
          state_d = CLEAR;
        end
      end
      SCAN: begin
        if (scan_issue) fft_adr = scan_adr_q;
        else            state_d = REPORT;
      end
      REPORT: begin
        result_valid = 1'b1;
        state_d      = enable ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      wait_cnt_q   <= '0;
      scan_adr_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_bin_q     <= '0;
      peak_bin     <= '0;
      peak_mag     <= '0;
      drop_count   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == CLEAR)  sample_cnt_q <= '0;
      else if (fft_load)     sample_cnt_q <= sample_cnt_q + M'(1);

      if (state_q == START)     wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + ww'(1);

      // Bin 0 (DC) is never read; the scan starts at bin 1.
      if (state_q == WAIT)  scan_adr_q <= M'(1);
      else if (scan_issue)  scan_adr_q <= scan_adr_q + M'(1);

      // Read data for the address issued now arrives next cycle.
      rd_valid_q <= scan_issue;
      rd_bin_q   <= scan_adr_q;

      if (drain) begin
        peak_bin <= max_bin;
        peak_mag <= max_mag;
      end

      if (sample_valid && !sample_ready && enable && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

  fft_peak_tracker #(
    .bit_width(bit_width),
    .M        (M)
  ) u_peak (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == CLEAR),
    .valid  (rd_valid_q),
    .bin    (rd_bin_q),
    .data   (fft_rd),
    .max_bin(max_bin),
    .max_mag(max_mag)
  );

endmodule
